// File: rtl/pdm_decimator.sv
// ---------------------------------------------------------------------------
// pdm_decimator
//   Turns a 1-bit PDM microphone stream into 8-bit unsigned PCM. It counts the
//   ones over a window of DECIM enabled cycles, then smooths the window totals
//   with a 4-tap moving average. dout holds between updates, and dvalid
//   strobes once per new sample.
//
// Parameters
//   DECIM  window length in enabled mclk cycles (4..255, so the count fits 8 bits)
//   PH_W   phase counter width (2**PH_W > DECIM-1)
//
// Ports
//   mclk     in   clock; all state updates on the rising edge
//   reset    in   synchronous, active-high
//   enable   in   consume one PDM bit this cycle; when low the window freezes
//   micData  in   raw PDM bit, asynchronous to mclk
//   dout     out  averaged PCM sample, 0..DECIM
//   dvalid   out  one-cycle pulse in the cycle dout takes a new value
//   primed   out  high once 4 windows have completed since reset
// ---------------------------------------------------------------------------
module pdm_decimator #(
   parameter int unsigned DECIM = 255,
   parameter int unsigned PH_W  = 8
) (
   input  logic       mclk,
   input  logic       reset,
   input  logic       enable,
   input  logic       micData,
   output logic [7:0] dout,
   output logic       dvalid,
   output logic       primed
);

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

   // Two-flop synchronizer for the asynchronous PDM input.
   logic            sync1_q, sync2_q;

   // Window stage.
   logic [PH_W-1:0] phase_q, phase_d;
   logic [7:0]      acc_q, acc_d;
   logic [7:0]      hist_q [4];
   logic [7:0]      hist_d [4];
   logic            close_q, close_d;
   logic [2:0]      wcount_q, wcount_d;
   logic [7:0]      win;

   // Average stage.
   logic [9:0]      sum;
   logic [7:0]      dout_q, dout_d;
   logic            dvalid_q, dvalid_d;
   logic            primed_q, primed_d;

   always_comb begin
      // NOTE: every variable gets a default here so no path leaves it
      // unassigned; an unassigned path would infer a latch.
      phase_d  = phase_q;
      acc_d    = acc_q;
      hist_d   = hist_q;
      close_d  = 1'b0;
      wcount_d = wcount_q;
      dout_d   = dout_q;
      dvalid_d = 1'b0;
      primed_d = primed_q;

      // The window total includes the bit being consumed in the close cycle.
      // It cannot overflow because DECIM <= 255.
      win = acc_q + {7'd0, sync2_q};

      if (enable) begin
         if (phase_q == PH_LAST) begin
            phase_d   = '0;
            acc_d     = '0;
            hist_d[0] = win;
            hist_d[1] = hist_q[0];
            hist_d[2] = hist_q[1];
            hist_d[3] = hist_q[2];
            close_d   = 1'b1;
            if (wcount_q != 3'd7) begin
               wcount_d = wcount_q + 3'd1;
            end
         end else begin
            phase_d = phase_q + 1'b1;
            acc_d   = win;
         end
      end

      // 10-bit zero-extended sum; the divide by 4 floors and never saturates.
      sum = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} +
            {2'b00, hist_q[2]} + {2'b00, hist_q[3]};

      if (close_q) begin
         dout_d   = 8'(sum >> 2);
         dvalid_d = 1'b1;
         // wcount already includes this close, so primed rises with the
         // 4th dvalid pulse.
         if (wcount_q >= 3'd4) begin
            primed_d = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values no matter what order the statements are in.
   always_ff @(posedge mclk) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         phase_q  <= '0;
         acc_q    <= '0;
         // NOTE: the history is only four registers, and it must start at zero
         // for the ramp-up, so it is reset like ordinary state instead of being
         // treated as an unreset memory.
         for (int i = 0; i < 4; i++) begin
            hist_q[i] <= '0;
         end
         close_q  <= 1'b0;
         wcount_q <= '0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         primed_q <= 1'b0;
      end else begin
         sync1_q  <= micData;
         sync2_q  <= sync1_q;
         phase_q  <= phase_d;
         acc_q    <= acc_d;
         hist_q   <= hist_d;
         close_q  <= close_d;
         wcount_q <= wcount_d;
         dout_q   <= dout_d;
         dvalid_q <= dvalid_d;
         primed_q <= primed_d;
      end
   end

   assign dout   = dout_q;
   assign dvalid = dvalid_q;
   assign primed = primed_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// ---------------------------------------------------------------------------
// tb_pdm_decimator
//   Self-checking bench for pdm_decimator with DECIM = 255. A reference model
//   keeps the last four window totals as plain integers and recomputes the
//   expected outputs every cycle. Directed scenarios are followed by a
//   randomized run.
// ---------------------------------------------------------------------------
module tb_pdm_decimator;

   localparam int D = 255;

   logic       mclk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       micData = 1'b0;
   logic [7:0] dout;
   logic       dvalid;
   logic       primed;

   int checks = 0;
   int failures = 0;

   pdm_decimator #(.DECIM(D), .PH_W(8)) dut (
      .mclk    (mclk),
      .reset   (reset),
      .enable  (enable),
      .micData (micData),
      .dout    (dout),
      .dvalid  (dvalid),
      .primed  (primed)
   );

   always #5 mclk = ~mclk;

   // Reference model state.
   int m_d1, m_d2;          // the micData bit reaches the window two edges late
   int m_ones, m_nbits;     // ones and enabled bits in the open window
   int m_win [4];           // window totals, index 0 newest
   int m_ncl;               // windows closed since reset
   bit m_pend;              // a window closed on the previous edge
   int e_dout, e_dvalid, e_primed;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit rst, input bit en, input bit mic);
      int b;
      if (rst) begin
         m_d1 = 0; m_d2 = 0; m_ones = 0; m_nbits = 0; m_ncl = 0; m_pend = 0;
         for (int i = 0; i < 4; i++) m_win[i] = 0;
         e_dout = 0; e_dvalid = 0; e_primed = 0;
         return;
      end
      b = m_d2;
      m_d2 = m_d1;
      m_d1 = int'(mic);
      if (m_pend) begin
         e_dout   = (m_win[0] + m_win[1] + m_win[2] + m_win[3]) / 4;
         e_dvalid = 1;
         if (m_ncl >= 4) e_primed = 1;
      end else begin
         e_dvalid = 0;
      end
      m_pend = 0;
      if (en) begin
         m_ones += b;
         m_nbits++;
         if (m_nbits == D) begin
            m_win[3] = m_win[2];
            m_win[2] = m_win[1];
            m_win[1] = m_win[0];
            m_win[0] = m_ones;
            m_ones = 0;
            m_nbits = 0;
            m_pend = 1;
            m_ncl++;
         end
      end
   endtask

   // One clock: drive the inputs, let the edge happen, then compare outputs
   // 1 time unit later, away from the edge.
   task automatic step(input bit rst, input bit en, input bit mic);
      reset = rst;
      enable = en;
      micData = mic;
      @(posedge mclk);
      model_edge(rst, en, mic);
      #1;
      check("dout", int'(dout), e_dout);
      check("dvalid", int'(dvalid), e_dvalid);
      check("primed", int'(primed), e_primed);
   endtask

   // Steps until dvalid is seen, with a bounded budget. Returns the step count.
   task automatic run_to_dvalid(input bit en, input bit mic, output int n);
      bit found = 0;
      n = 0;
      for (int i = 0; i < 4 * D && !found; i++) begin
         step(1'b0, en, mic);
         n++;
         if (dvalid === 1'b1) found = 1;
      end
      check("dvalid_timeout", int'(found), 1);
   endtask

   initial begin
      int n;
      int saved;

      // Reset held for 3 cycles with micData toggling.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'(i));
      check("rst_dout", int'(dout), 0);
      check("rst_primed", int'(primed), 0);

      // Full-scale input: the first dvalid comes DECIM+1 cycles after release.
      run_to_dvalid(1'b1, 1'b1, n);
      check("first_latency", n, D + 1);
      check("ramp_first", int'(dout), 63);
      for (int i = 0; i < 4 * D; i++) step(1'b0, 1'b1, 1'b1);
      check("full_scale", int'(dout), 255);
      check("full_primed", int'(primed), 1);

      // Reset mid-window: the outputs clear, and primed returns only after
      // four new windows.
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check("midrst_dout", int'(dout), 0);
      check("midrst_primed", int'(primed), 0);
      for (int i = 1; i <= 4 * D; i++) step(1'b0, 1'b1, 1'b1);
      check("reprime_before", int'(primed), 0);
      step(1'b0, 1'b1, 1'b1);
      check("reprime_pulse", int'(dvalid), 1);
      check("reprime_after", int'(primed), 1);

      // Silence: the output decays to 0, and the dvalid period equals DECIM.
      for (int i = 0; i < 6 * D; i++) step(1'b0, 1'b1, 1'b0);
      check("silence", int'(dout), 0);
      run_to_dvalid(1'b1, 1'b0, n);
      run_to_dvalid(1'b1, 1'b0, n);
      check("silence_period", n, D);

      // Half scale: ones land on the even window phases, giving 128 per window.
      step(1'b1, 1'b1, 1'b0);
      for (int s = 1; s <= 6 * D + 1; s++) step(1'b0, 1'b1, 1'(((s + 1) % D) % 2 == 0));
      check("half_scale", int'(dout), 128);

      // Enable gap of 100 cycles mid-window: no dvalid, and dout holds.
      step(1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b1);
      saved = int'(dout);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b1);
      check("gap_hold", int'(dout), saved);
      run_to_dvalid(1'b1, 1'b1, n);
      check("gap_delay", 150 + n, D + 1 + 100);
      check("gap_value", int'(dout), 63);

      // enable toggling every cycle with random data.
      for (int i = 0; i < 4 * D; i++) step(1'b0, 1'(i % 2), 1'($urandom_range(0, 1)));

      // Fully random operation, with an occasional reset.
      for (int i = 0; i < 6000; i++)
         step(1'($urandom_range(0, 1999) == 0), 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
